gf163_reduce_pipe: RTL and testbench
====================================

// Module: gf163_reduce_pipe
// PURPOSE
//  Two-stage elastic pipeline that reduces the 325-bit GF(2)[x] product from the
//  overlap-free Karatsuba combiner tree to a 163-bit element of GF(2^163).
//  Reduction polynomial: f(x) = x^M + x^P1 + x^P2 + x^P3 + 1 (NIST B/K-163).
//  Sits directly downstream of the top-level overlap combiner.
//  Uses valid/ready on both sides so it can be stalled by the point-arithmetic controller.
// PARAMETERS
//  M   163  field degree; input width 2*M-1, output width M
//  P1  7    highest middle exponent of f(x); must satisfy P1 <= (M-1)/2
//  P2  6    middle exponent of f(x)
//  P3  3    lowest middle exponent of f(x)
// PORTS
//  clk        in   1      rising-edge clock
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      in_prod is valid
//  in_ready   out  1      stage 1 can accept this cycle (combinational)
//  in_prod    in   2*M-1  unreduced product c(x); bit i = coefficient of x^i
//  out_valid  out  1      out_red is valid (registered)
//  out_ready  in   1      consumer accepts out_red
//  out_red    out  M      c(x) mod f(x) (registered)
//  busy       out  1      high when either stage holds valid data
// BEHAVIOUR
//  Reset (async assert, sync release): s1_valid = s2_valid = 0, out_valid = 0,
//   out_red = 0, busy = 0. Stage data registers are also cleared to 0.
//  Stage 1 (fold 1), registered on transfer into S1:
//   h = c[2M-2:M], l = c[M-1:0]
//   t = l ^ h ^ (h<<P3) ^ (h<<P2) ^ (h<<P1); t is M+P1-1 bits wide (169 by default)
//  Stage 2 (fold 2), registered on transfer into S2, which drives out_*:
//   h2 = t[M+P1-2:M] (P1-1 bits), r = t[M-1:0] ^ h2 ^ (h2<<P3) ^ (h2<<P2) ^ (h2<<P1)
//   No carry beyond bit M-1 is possible given the P1 constraint.
//  Handshake, per stage:
//   adv2 = !s2_valid | out_ready; adv1 = !s1_valid | (s2_valid_next_takes)
//   in_ready = !s1_valid | adv2. An input transfers when in_valid & in_ready.
//   S2 loads S1 when s1_valid & adv2. S1 holds its data while S2 is stalled.
//  Latency: 2 cycles from input transfer to out_valid with no backpressure.
//   Throughput: 1 result per cycle.
//  out_red and out_valid are held stable while out_valid & !out_ready.
//   in_prod is ignored when !in_valid.
//  Simultaneous push and pop on a full pipe: all three transfers happen in the
//   same cycle; no bubble is introduced.
//  Full pipe with out_ready = 0: in_ready = 0 and no data is dropped or duplicated.
//  Reset mid-operation: in-flight data is discarded and no partial result
//   appears after release.
//  The block does not enforce a degree bound on in_prod; all 2M-1 bits are
//   always folded.
// STRUCTURE
//  Shared package gf163_pkg: M, P1, P2, P3 constants; typedefs prod_t [2M-2:0],
//   fold_t [M+P1-2:0], elem_t [M-1:0].
//  Sub-module gf_fold (combinational; parameters IN_W, M, P1, P2, P3): a single
//   fold step, instantiated twice with IN_W = 2M-1 and IN_W = M+P1-1.
//  Top level: two valid/data register stages and the ready chain only.
// TESTING
//  1 in_prod = 1<<163, out_ready = 1 -> out_red = 0xC9 two cycles later, out_valid for 1 cycle.
//  2 in_prod = 1<<324 -> out_red has bits {161,12,10,5,1} set (low word 0x1422, plus bit 161).
//  3 in_prod = 0x5A (degree < M) -> out_red = 0x5A unchanged, latency exactly 2.
//  4 Random a,b: stream 1000 products with in_valid and out_ready random ~70%
//    -> results in order, each equals a software mod-f model, no drops or duplicates.
//  5 Fill pipe, hold out_ready = 0 for 5 cycles -> in_ready = 0, out_red stable,
//    busy = 1; then assert out_ready -> the two results drain back-to-back.
//  6 Assert rst_n = 0 with both stages valid -> out_valid, out_red, busy = 0
//    immediately; after release in_ready = 1 and no stale output appears.

Source files
------------

// File: rtl/gf163_pkg.sv
// gf163_pkg: field constants and datapath types for GF(2^163) reduction
package gf163_pkg;
  localparam int M  = 163;
  localparam int P1 = 7;
  localparam int P2 = 6;
  localparam int P3 = 3;
  typedef logic [2*M-2:0]  prod_t;
  typedef logic [M+P1-2:0] fold_t;
  typedef logic [M-1:0]    elem_t;
endpackage

// File: rtl/gf163_reduce_pipe_if.sv
// gf163_reduce_pipe_if: valid/ready input and output channels of the reducer
interface gf163_reduce_pipe_if;
  import gf163_pkg::*;
  logic  in_valid;
  logic  in_ready;
  prod_t in_prod;
  logic  out_valid;
  logic  out_ready;
  elem_t out_red;
  logic  busy;
  modport slave (input in_valid, in_prod, out_ready, output in_ready, out_valid, out_red, busy);
  modport master (output in_valid, in_prod, out_ready, input in_ready, out_valid, out_red, busy);
endinterface

// File: rtl/gf_fold.sv
// gf_fold: one reduction fold, c[M-1:0] ^ h*(1 + x^P3 + x^P2 + x^P1) with h = c[IN_W-1:M]
module gf_fold #(
  parameter int IN_W = 325,
  parameter int M = 163,
  parameter int P1 = 7,
  parameter int P2 = 6,
  parameter int P3 = 3,
  parameter int OUT_W = (IN_W - M + P1 > M) ? IN_W - M + P1 : M
) (
  input  logic [IN_W-1:0]  c,
  output logic [OUT_W-1:0] t
);
  logic [OUT_W-1:0] h;
  always_comb begin
    h = OUT_W'(c[IN_W-1:M]);
    t = OUT_W'(c[M-1:0]) ^ h ^ (h << P3) ^ (h << P2) ^ (h << P1);
  end
endmodule

// File: rtl/gf163_reduce_pipe.sv
// gf163_reduce_pipe: two-stage elastic pipeline reducing a 325-bit product mod f(x)
module gf163_reduce_pipe
  import gf163_pkg::*;
(
  input logic clk,
  input logic rst_n,
  gf163_reduce_pipe_if.slave io
);
  logic  s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
  fold_t s1_data_q, s1_data_d, fold1;
  elem_t s2_data_q, s2_data_d, fold2;
  logic  adv2, in_rdy, in_fire, s2_load;
  gf_fold #(.IN_W(2*M-1), .M(M), .P1(P1), .P2(P2), .P3(P3)) u_fold1 (.c(io.in_prod), .t(fold1));
  gf_fold #(.IN_W(M+P1-1), .M(M), .P1(P1), .P2(P2), .P3(P3)) u_fold2 (.c(s1_data_q), .t(fold2));
  // S1 may refill in the same cycle it hands off, so a full pipe streams without bubbles
  always_comb begin
    adv2       = !s2_valid_q | io.out_ready;
    in_rdy     = !s1_valid_q | adv2;
    in_fire    = io.in_valid & in_rdy;
    s2_load    = s1_valid_q & adv2;
    s1_valid_d = in_fire ? 1'b1 : s2_load ? 1'b0 : s1_valid_q;
    s1_data_d  = in_fire ? fold1 : s1_data_q;
    s2_valid_d = s2_load ? 1'b1 : io.out_ready ? 1'b0 : s2_valid_q;
    s2_data_d  = s2_load ? fold2 : s2_data_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      s2_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_data_q  <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s2_valid_q <= s2_valid_d;
      s1_data_q  <= s1_data_d;
      s2_data_q  <= s2_data_d;
    end
  assign io.in_ready  = in_rdy;
  assign io.out_valid = s2_valid_q;
  assign io.out_red   = s2_data_q;
  assign io.busy      = s1_valid_q | s2_valid_q;
endmodule

// File: tb/tb_gf163_reduce_pipe.sv
// tb_gf163_reduce_pipe: directed and streamed checks of the GF(2^163) reduction pipeline
module tb_gf163_reduce_pipe;
  logic clk = 0;
  logic rst_n = 0;
  int n_checks = 0;
  int n_fail = 0;
  localparam logic [324:0] F = (325'd1 << 163) | 325'hC9;
  gf163_reduce_pipe_if io ();
  gf163_reduce_pipe dut (.clk(clk), .rst_n(rst_n), .io(io));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [324:0] obs, input logic [324:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  function automatic logic [162:0] mod_f(input logic [324:0] c);
    logic [324:0] r;
    r = c;
    for (int i = 324; i >= 163; i--)
      if (r[i]) r = r ^ (F << (i - 163));
    return r[162:0];
  endfunction
  function automatic logic [162:0] rnd163();
    logic [191:0] w;
    w = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    return w[162:0];
  endfunction
  function automatic logic [324:0] clmul(input logic [162:0] a, input logic [162:0] b);
    logic [324:0] p;
    p = '0;
    for (int i = 0; i < 163; i++)
      if (b[i]) p = p ^ (325'(a) << i);
    return p;
  endfunction
  task automatic single(input string tag, input logic [324:0] prod, input logic [162:0] exp);
    io.in_valid = 1;
    io.in_prod = prod;
    io.out_ready = 1;
    #1;
    check({tag, "_in_ready"}, 325'(io.in_ready), 325'd1);
    step();
    io.in_valid = 0;
    io.in_prod = '1;
    check({tag, "_valid_c1"}, 325'(io.out_valid), 325'd0);
    step();
    check({tag, "_valid_c2"}, 325'(io.out_valid), 325'd1);
    check({tag, "_red"}, 325'(io.out_red), 325'(exp));
    step();
    check({tag, "_valid_c3"}, 325'(io.out_valid), 325'd0);
  endtask
  initial begin
    logic [324:0] pend, q[$];
    logic have;
    int sent, got, cyc;
    io.in_valid = 0;
    io.in_prod = '0;
    io.out_ready = 0;
    step();
    step();
    check("rst_out_valid", 325'(io.out_valid), 325'd0);
    check("rst_out_red", 325'(io.out_red), 325'd0);
    check("rst_busy", 325'(io.busy), 325'd0);
    check("rst_in_ready", 325'(io.in_ready), 325'd1);
    rst_n = 1;
    step();
    single("x163", 325'd1 << 163, 163'hC9);
    single("x324", 325'd1 << 324, (163'd1 << 161) | 163'h1422);
    single("low5a", 325'h5A, 163'h5A);
    // stall: fill both stages, then hold the consumer off
    io.out_ready = 0;
    io.in_valid = 1;
    io.in_prod = 325'd1 << 163;
    step();
    io.in_prod = 325'h5A;
    step();
    io.in_prod = 325'h77;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("stall_in_ready", 325'(io.in_ready), 325'd0);
      check("stall_valid", 325'(io.out_valid), 325'd1);
      check("stall_red", 325'(io.out_red), 325'hC9);
      check("stall_busy", 325'(io.busy), 325'd1);
      step();
    end
    io.in_valid = 0;
    io.out_ready = 1;
    #1;
    check("drain_in_ready", 325'(io.in_ready), 325'd1);
    check("drain0_red", 325'(io.out_red), 325'hC9);
    step();
    check("drain1_valid", 325'(io.out_valid), 325'd1);
    check("drain1_red", 325'(io.out_red), 325'h5A);
    step();
    check("drain2_valid", 325'(io.out_valid), 325'd0);
    check("drain2_busy", 325'(io.busy), 325'd0);
    // reset with both stages holding data
    io.out_ready = 0;
    io.in_valid = 1;
    io.in_prod = 325'd1 << 324;
    step();
    step();
    io.in_valid = 0;
    check("prerst_busy", 325'(io.busy), 325'd1);
    #2 rst_n = 0;
    #1;
    check("midrst_valid", 325'(io.out_valid), 325'd0);
    check("midrst_red", 325'(io.out_red), 325'd0);
    check("midrst_busy", 325'(io.busy), 325'd0);
    step();
    rst_n = 1;
    io.out_ready = 1;
    #1;
    check("postrst_in_ready", 325'(io.in_ready), 325'd1);
    for (int i = 0; i < 3; i++) begin
      step();
      check("postrst_valid", 325'(io.out_valid), 325'd0);
    end
    // random stream against a long-division model
    sent = 0;
    got = 0;
    cyc = 0;
    have = 0;
    pend = '0;
    while ((sent < 1000 || q.size() != 0) && cyc < 20000) begin
      if (!have && sent < 1000) begin
        pend = clmul(rnd163(), rnd163());
        have = 1;
      end
      io.in_valid = have && ($urandom_range(9) < 7);
      io.in_prod = io.in_valid ? pend : 325'(~pend);
      io.out_ready = $urandom_range(9) < 7;
      #1;
      if (io.out_valid && io.out_ready) begin
        if (q.size() == 0) check("stream_extra", 325'(io.out_red), 325'hDEAD);
        else check("stream_red", 325'(io.out_red), 325'(mod_f(q.pop_front())));
        got++;
      end
      if (io.in_valid && io.in_ready) begin
        q.push_back(pend);
        sent++;
        have = 0;
      end
      @(posedge clk);
      #1;
      cyc++;
    end
    check("stream_timeout", 325'(cyc < 20000), 325'd1);
    check("stream_count", 325'(got), 325'd1000);
    io.in_valid = 0;
    io.out_ready = 1;
    step();
    check("stream_idle", 325'(io.busy), 325'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
